// File: rtl/fib2axis_rxctrl_pkg.sv
// ---------------------------------------------------------------------------
// fib_axis_pkg
// Shared definitions for the RX FIFO-to-AXI-Stream controller:
//   rd_state_t     one-hot read-side state encoding (also driven out for debug)
//   BCNT_*         field positions inside a byte-count FIFO word
//   WORDS_W        width of the per-frame word counter
//   last_tstrb()   byte-lane mask for the final beat of a frame
// ---------------------------------------------------------------------------
package fib_axis_pkg;

   typedef enum logic [3:0] {
      IDLE = 4'h1,
      BCNT = 4'h2,
      DATA = 4'h4,
      DONE = 4'h8
   } rd_state_t;

   localparam int unsigned BCNT_BYTES_MSB = 15;
   localparam int unsigned BCNT_ERR_BIT   = 31;

   // ceil(65535/8) = 8192 needs 14 bits
   localparam int unsigned WORDS_W = 14;

   // rem = bytes[2:0]; rem==0 means the last word is fully populated
   function automatic logic [7:0] last_tstrb(input logic [2:0] rem);
      logic [7:0] mask;
      mask = 8'hFF;
      if (rem != 3'd0) begin
         mask = (8'h01 << rem) - 8'h01;
      end
      return mask;
   endfunction

endpackage

// File: rtl/fib2axis_rxctrl_skid2.sv
// ---------------------------------------------------------------------------
// axis_skid2
// Two-entry registered FIFO holding stream beats between the data FIFO read
// port and the AXI-Stream output. The head entry is presented directly, so
// it stays stable while the sink stalls.
//   clk      clock
//   reset_   synchronous reset, active low (empties the buffer)
//   wr       write wr_data this cycle
//   wr_data  payload {tdata, tstrb, tlast, tuser}
//   pop      remove head entry this cycle
//   head     current head payload
//   occ      number of entries held (0..2)
// ---------------------------------------------------------------------------
module axis_skid2 #(
   parameter int unsigned W = 74
) (
   input  logic         clk,
   input  logic         reset_,
   input  logic         wr,
   input  logic [W-1:0] wr_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   occ
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         occ <= occ + {1'b0, wr} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/fib2axis_rxctrl.sv
// ---------------------------------------------------------------------------
// fib2axis_rxctrl
// Drains one frame at a time from the RX byte-count FIFO and data FIFO
// (both non-show-ahead, 1-cycle read latency) and replays it as an
// AXI-Stream master.
//   rx_mac_aclk            clock
//   reset_                 synchronous reset, active low
//   rx_axis_mac_*          AXI-Stream master (tdata/tvalid/tlast/tuser/tstrb,
//                          tready in)
//   rd_rxbcnt_fifo         bcnt FIFO word: [15:0] bytes, [31] error
//   rxbcnt_rdreq/rdempty   bcnt FIFO read handshake; rdusedw status only
//   rd_rxdata_fifo         data FIFO word
//   rxdata_rdreq/rdempty   data FIFO read handshake; rdusedw status only
//   rx_statistics_vector   {15'b0, err, bytes} of the last completed frame
//   rx_statistics_valid    1-cycle pulse at frame completion
//   bcnt_more_than_max     current frame exceeds MAX_FRAME bytes
//   axis_rd_state          one-hot state for debug
// ---------------------------------------------------------------------------
module fib2axis_rxctrl
   import fib_axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DATA_PTR   = 8,
   parameter int unsigned BCNT_WIDTH = 32,
   parameter int unsigned BCNT_PTR   = 2,
   parameter int unsigned MAX_FRAME  = 1518
) (
   input  logic                  rx_mac_aclk,
   input  logic                  reset_,
   output logic [DATA_WIDTH-1:0] rx_axis_mac_tdata,
   output logic                  rx_axis_mac_tvalid,
   output logic                  rx_axis_mac_tlast,
   output logic                  rx_axis_mac_tuser,
   output logic [7:0]            rx_axis_mac_tstrb,
   input  logic                  rx_axis_mac_tready,
   input  logic [BCNT_WIDTH-1:0] rd_rxbcnt_fifo,
   output logic                  rxbcnt_rdreq,
   input  logic                  rxbcnt_rdempty,
   input  logic [BCNT_PTR:0]     rxbcnt_rdusedw,
   input  logic [DATA_WIDTH-1:0] rd_rxdata_fifo,
   output logic                  rxdata_rdreq,
   input  logic                  rxdata_rdempty,
   input  logic [DATA_PTR:0]     rxdata_rdusedw,
   output logic [31:0]           rx_statistics_vector,
   output logic                  rx_statistics_valid,
   output logic                  bcnt_more_than_max,
   output logic [3:0]            axis_rd_state
);

   localparam int unsigned SKID_W = DATA_WIDTH + 10;

   rd_state_t          state;
   logic               latch_pend;
   logic [15:0]        bytes;
   logic               err;
   logic [WORDS_W-1:0] words_left;
   logic               inflight;
   logic               inflight_last;
   logic [1:0]         occ;
   logic [SKID_W-1:0]  head;
   logic [SKID_W-1:0]  wr_payload;
   logic               pop;
   logic [2:0]         outstanding;

   logic [15:0]        cap_bytes;
   logic               cap_err;
   logic [WORDS_W-1:0] cap_words;

   logic               unused_status;
   assign unused_status = ^{rxbcnt_rdusedw, rxdata_rdusedw,
                            rd_rxbcnt_fifo[BCNT_ERR_BIT-1:BCNT_BYTES_MSB+1]};

   assign cap_bytes = rd_rxbcnt_fifo[BCNT_BYTES_MSB:0];
   assign cap_err   = rd_rxbcnt_fifo[BCNT_ERR_BIT];
   assign cap_words = WORDS_W'(({1'b0, cap_bytes} + 17'd7) >> 3);

   assign axis_rd_state = state;

   assign {rx_axis_mac_tdata, rx_axis_mac_tstrb,
           rx_axis_mac_tlast, rx_axis_mac_tuser} = head;
   assign rx_axis_mac_tvalid = (occ != 2'd0);
   assign pop                = rx_axis_mac_tvalid & rx_axis_mac_tready;

   // Beat attributes are fixed when the word is issued, not when it is
   // popped: the read that takes words_left from 1 to 0 carries the last word.
   assign wr_payload = {rd_rxdata_fifo,
                        inflight_last ? last_tstrb(bytes[2:0]) : 8'hFF,
                        inflight_last,
                        err & inflight_last};

   // Never allow more than two words between skid contents and the read
   // still in flight, so the skid cannot overflow while tready is low.
   always_comb begin
      outstanding  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      rxdata_rdreq = (state == DATA) && (words_left != '0) &&
                     !rxdata_rdempty && (outstanding < 3'd2);
   end

   always_ff @(posedge rx_mac_aclk) begin
      if (!reset_) begin
         state                <= IDLE;
         latch_pend           <= 1'b0;
         rxbcnt_rdreq         <= 1'b0;
         bytes                <= '0;
         err                  <= 1'b0;
         words_left           <= '0;
         inflight             <= 1'b0;
         inflight_last        <= 1'b0;
         rx_statistics_vector <= '0;
         rx_statistics_valid  <= 1'b0;
         bcnt_more_than_max   <= 1'b0;
      end else begin
         rxbcnt_rdreq        <= 1'b0;
         rx_statistics_valid <= 1'b0;
         inflight            <= rxdata_rdreq;
         inflight_last       <= rxdata_rdreq && (words_left == WORDS_W'(1));

         case (state)
            IDLE: begin
               if (!rxbcnt_rdempty) begin
                  state        <= BCNT;
                  rxbcnt_rdreq <= 1'b1;
                  latch_pend   <= 1'b0;
               end
            end

            // First BCNT cycle issues the read; the second latches the word.
            BCNT: begin
               if (!latch_pend) begin
                  latch_pend <= 1'b1;
               end else begin
                  latch_pend         <= 1'b0;
                  bytes              <= cap_bytes;
                  err                <= cap_err;
                  words_left         <= cap_words;
                  bcnt_more_than_max <= (32'(cap_bytes) > MAX_FRAME);
                  if (cap_bytes == 16'd0) begin
                     state                <= DONE;
                     rx_statistics_valid  <= 1'b1;
                     rx_statistics_vector <= {15'b0, cap_err, cap_bytes};
                  end else begin
                     state <= DATA;
                  end
               end
            end

            DATA: begin
               if (rxdata_rdreq) begin
                  words_left <= words_left - WORDS_W'(1);
               end
               if (pop && rx_axis_mac_tlast) begin
                  state                <= DONE;
                  rx_statistics_valid  <= 1'b1;
                  rx_statistics_vector <= {15'b0, err, bytes};
               end
            end

            DONE: begin
               bcnt_more_than_max <= 1'b0;
               state              <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   axis_skid2 #(
      .W (SKID_W)
   ) u_skid (
      .clk     (rx_mac_aclk),
      .reset_  (reset_),
      .wr      (inflight),
      .wr_data (wr_payload),
      .pop     (pop),
      .head    (head),
      .occ     (occ)
   );

endmodule

// File: tb/tb_fib2axis_rxctrl.sv
module tb_fib2axis_rxctrl;

   logic        rx_mac_aclk = 1'b0;
   logic        reset_;
   logic [63:0] rx_axis_mac_tdata;
   logic        rx_axis_mac_tvalid;
   logic        rx_axis_mac_tlast;
   logic        rx_axis_mac_tuser;
   logic [7:0]  rx_axis_mac_tstrb;
   logic        rx_axis_mac_tready;
   logic [31:0] rd_rxbcnt_fifo;
   logic        rxbcnt_rdreq;
   logic        rxbcnt_rdempty;
   logic [2:0]  rxbcnt_rdusedw;
   logic [63:0] rd_rxdata_fifo;
   logic        rxdata_rdreq;
   logic        rxdata_rdempty;
   logic [8:0]  rxdata_rdusedw;
   logic [31:0] rx_statistics_vector;
   logic        rx_statistics_valid;
   logic        bcnt_more_than_max;
   logic [3:0]  axis_rd_state;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [31:0] bq[$];
   logic [63:0] dq[$];

   logic [73:0] beat;
   assign beat = {rx_axis_mac_tdata, rx_axis_mac_tstrb, rx_axis_mac_tlast, rx_axis_mac_tuser};

   always #5 rx_mac_aclk = ~rx_mac_aclk;

   fib2axis_rxctrl dut (
      .rx_mac_aclk          (rx_mac_aclk),
      .reset_               (reset_),
      .rx_axis_mac_tdata    (rx_axis_mac_tdata),
      .rx_axis_mac_tvalid   (rx_axis_mac_tvalid),
      .rx_axis_mac_tlast    (rx_axis_mac_tlast),
      .rx_axis_mac_tuser    (rx_axis_mac_tuser),
      .rx_axis_mac_tstrb    (rx_axis_mac_tstrb),
      .rx_axis_mac_tready   (rx_axis_mac_tready),
      .rd_rxbcnt_fifo       (rd_rxbcnt_fifo),
      .rxbcnt_rdreq         (rxbcnt_rdreq),
      .rxbcnt_rdempty       (rxbcnt_rdempty),
      .rxbcnt_rdusedw       (rxbcnt_rdusedw),
      .rd_rxdata_fifo       (rd_rxdata_fifo),
      .rxdata_rdreq         (rxdata_rdreq),
      .rxdata_rdempty       (rxdata_rdempty),
      .rxdata_rdusedw       (rxdata_rdusedw),
      .rx_statistics_vector (rx_statistics_vector),
      .rx_statistics_valid  (rx_statistics_valid),
      .bcnt_more_than_max   (bcnt_more_than_max),
      .axis_rd_state        (axis_rd_state)
   );

   // Non-show-ahead FIFO models: data appears the cycle after rdreq.
   always @(posedge rx_mac_aclk) begin
      logic [31:0] bw;
      logic [63:0] dw;
      cyc++;
      if (rxbcnt_rdreq) begin
         compared++;
         if (bq.size() == 0) begin
            mismatched++;
            $display("FAIL bcnt_read_empty: got read of empty bcnt fifo, required non-empty");
         end else begin
            bw = bq.pop_front();
            rd_rxbcnt_fifo <= bw;
         end
      end
      if (rxdata_rdreq) begin
         compared++;
         if (dq.size() == 0) begin
            mismatched++;
            $display("FAIL data_read_empty: got read of empty data fifo, required non-empty");
         end else begin
            dw = dq.pop_front();
            rd_rxdata_fifo <= dw;
         end
      end
      rxbcnt_rdempty <= (bq.size() == 0);
      rxdata_rdempty <= (dq.size() == 0);
   end

   task automatic push_words(input logic [31:0] base, input int from, input int to);
      for (int i = from; i < to; i++) dq.push_back({base, 32'(i)});
      rxdata_rdempty = (dq.size() == 0);
   endtask

   task automatic push_bcnt(input logic [31:0] b);
      bq.push_back(b);
      rxbcnt_rdempty = 1'b0;
   endtask

   // Consumes one frame; word k of a frame is {base, k}.
   // mode 0: tready always 1; mode 1: tready pattern 1,0,0 repeating.
   task automatic collect(input string name, input logic [31:0] base, input int nwords,
                          input logic [7:0] lstrb, input logic err, input logic exp_mtm,
                          input int mode, input int stall_after, input int stall_len,
                          output int first_cyc, output int last_cyc);
      int k = 0;
      int j = 0;
      int bad;
      logic held_v = 1'b0;
      logic [73:0] held;
      logic [73:0] expv;
      logic [7:0] sv;
      logic lv;
      first_cyc = -1;
      last_cyc  = -1;
      for (int t = 0; t < 1000 && k < nwords; t++) begin
         @(negedge rx_mac_aclk);
         if (held_v) begin
            compared++;
            if (beat !== held) begin
               mismatched++;
               $display("FAIL %s_hold: got %h required %h", name, beat, held);
            end
            held_v = 1'b0;
         end
         if (rx_axis_mac_tvalid && first_cyc < 0) begin
            first_cyc = cyc;
            compared++;
            if (bcnt_more_than_max !== exp_mtm) begin
               mismatched++;
               $display("FAIL %s_mtm: got %b required %b", name, bcnt_more_than_max, exp_mtm);
            end
         end
         rx_axis_mac_tready = (mode == 0) || (j % 3 == 0);
         j++;
         if (rx_axis_mac_tvalid) begin
            if (rx_axis_mac_tready) begin
               lv = (k == nwords - 1);
               sv = lv ? lstrb : 8'hFF;
               expv = {base, 32'(k), sv, lv, err & lv};
               compared++;
               if (beat !== expv) begin
                  mismatched++;
                  $display("FAIL %s_beat%0d: got %h required %h", name, k, beat, expv);
               end
               if (lv) last_cyc = cyc + 1;
               k++;
               if (stall_len > 0 && k == stall_after) begin
                  bad = 0;
                  for (int s = 0; s < stall_len; s++) begin
                     @(negedge rx_mac_aclk);
                     if (rx_axis_mac_tvalid !== 1'b0) bad++;
                  end
                  compared++;
                  if (bad != 0) begin
                     mismatched++;
                     $display("FAIL %s_gap: got %0d valid cycles required 0", name, bad);
                  end
                  push_words(base, stall_after, nwords);
               end
            end else begin
               held   = beat;
               held_v = 1'b1;
            end
         end
      end
      compared++;
      if (k !== nwords) begin
         mismatched++;
         $display("FAIL %s_timeout: got %0d beats required %0d", name, k, nwords);
      end
   endtask

   // Called right after collect: expects DONE with stats pulse, then IDLE.
   task automatic check_done(input string name, input logic [31:0] vec);
      @(negedge rx_mac_aclk);
      compared++;
      if ({rx_statistics_valid, rx_statistics_vector, axis_rd_state, rx_axis_mac_tvalid}
          !== {1'b1, vec, 4'h8, 1'b0}) begin
         mismatched++;
         $display("FAIL %s_done: got valid=%b vec=%h state=%h tvalid=%b required 1 %h 8 0",
                  name, rx_statistics_valid, rx_statistics_vector, axis_rd_state, rx_axis_mac_tvalid, vec);
      end
      @(negedge rx_mac_aclk);
      compared++;
      if ({rx_statistics_valid, axis_rd_state, bcnt_more_than_max} !== {1'b0, 4'h1, 1'b0}) begin
         mismatched++;
         $display("FAIL %s_idle: got valid=%b state=%h mtm=%b required 0 1 0",
                  name, rx_statistics_valid, axis_rd_state, bcnt_more_than_max);
      end
   endtask

   task automatic check_all_zero(input string name);
      compared++;
      if ({rx_axis_mac_tdata, rx_axis_mac_tvalid, rx_axis_mac_tlast, rx_axis_mac_tuser,
           rx_axis_mac_tstrb, rxbcnt_rdreq, rxdata_rdreq, rx_statistics_vector,
           rx_statistics_valid, bcnt_more_than_max, axis_rd_state} !== {111'h0, 4'h1}) begin
         mismatched++;
         $display("FAIL %s: got tvalid=%b tdata=%h rdreq=%b/%b stats=%h/%b mtm=%b state=%h required zeros state=1",
                  name, rx_axis_mac_tvalid, rx_axis_mac_tdata, rxbcnt_rdreq, rxdata_rdreq,
                  rx_statistics_vector, rx_statistics_valid, bcnt_more_than_max, axis_rd_state);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge rx_mac_aclk);
      check_all_zero("reset_outputs");
      reset_ = 1'b1;
      @(negedge rx_mac_aclk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_basic64();
      int e0, fc, lc;
      @(negedge rx_mac_aclk);
      rx_axis_mac_tready = 1'b1;
      push_words(32'hA000_0001, 0, 8);
      push_bcnt(32'd64);
      e0 = cyc + 1;
      @(negedge rx_mac_aclk);
      compared++;
      if ({axis_rd_state, rxbcnt_rdreq} !== {4'h2, 1'b1}) begin
         mismatched++;
         $display("FAIL lat_bcnt_req: got state=%h rdreq=%b required 2 1", axis_rd_state, rxbcnt_rdreq);
      end
      @(negedge rx_mac_aclk);
      compared++;
      if ({axis_rd_state, rxbcnt_rdreq} !== {4'h2, 1'b0}) begin
         mismatched++;
         $display("FAIL lat_latch: got state=%h rdreq=%b required 2 0", axis_rd_state, rxbcnt_rdreq);
      end
      @(negedge rx_mac_aclk);
      compared++;
      if ({axis_rd_state, rxdata_rdreq, rx_axis_mac_tvalid} !== {4'h4, 1'b1, 1'b0}) begin
         mismatched++;
         $display("FAIL lat_data_req: got state=%h rdreq=%b tvalid=%b required 4 1 0",
                  axis_rd_state, rxdata_rdreq, rx_axis_mac_tvalid);
      end
      collect("f64", 32'hA000_0001, 8, 8'hFF, 1'b0, 1'b0, 0, 0, 0, fc, lc);
      compared++;
      if (fc !== e0 + 4) begin
         mismatched++;
         $display("FAIL lat_first_valid: got cycle %0d required %0d", fc, e0 + 4);
      end
      check_done("f64", 32'h0000_0040);
   endtask

   task automatic test_rem61();
      int fc, lc;
      @(negedge rx_mac_aclk);
      push_words(32'hA000_0002, 0, 8);
      push_bcnt(32'd61);
      collect("f61", 32'hA000_0002, 8, 8'h1F, 1'b0, 1'b0, 0, 0, 0, fc, lc);
      check_done("f61", 32'h0000_003D);
   endtask

   task automatic test_err_backpressure();
      int fc, lc;
      @(negedge rx_mac_aclk);
      push_words(32'hA000_0003, 0, 8);
      push_bcnt(32'h8000_003C);
      collect("err60", 32'hA000_0003, 8, 8'h0F, 1'b1, 1'b0, 1, 0, 0, fc, lc);
      rx_axis_mac_tready = 1'b1;
      check_done("err60", 32'h0001_003C);
   endtask

   task automatic test_stall();
      int fc, lc;
      @(negedge rx_mac_aclk);
      push_words(32'hA000_0004, 0, 3);
      push_bcnt(32'd64);
      collect("stall", 32'hA000_0004, 8, 8'hFF, 1'b0, 1'b0, 0, 3, 10, fc, lc);
      check_done("stall", 32'h0000_0040);
   endtask

   task automatic test_zero();
      int nv = 0;
      int np = 0;
      logic [31:0] vec = 32'hFFFF_FFFF;
      @(negedge rx_mac_aclk);
      push_bcnt(32'd0);
      for (int t = 0; t < 12; t++) begin
         @(negedge rx_mac_aclk);
         if (rx_axis_mac_tvalid) nv++;
         if (rx_statistics_valid) begin
            np++;
            vec = rx_statistics_vector;
         end
      end
      compared++;
      if (nv !== 0) begin
         mismatched++;
         $display("FAIL zero_beats: got %0d beats required 0", nv);
      end
      compared++;
      if (np !== 1) begin
         mismatched++;
         $display("FAIL zero_pulse: got %0d pulses required 1", np);
      end
      compared++;
      if (vec !== 32'h0) begin
         mismatched++;
         $display("FAIL zero_vec: got %h required 00000000", vec);
      end
   endtask

   task automatic test_back_to_back();
      int fc1, lc1, fc2, lc2;
      @(negedge rx_mac_aclk);
      push_words(32'hB000_0001, 0, 8);
      push_words(32'hB000_0002, 0, 200);
      push_bcnt(32'd64);
      push_bcnt(32'd1600);
      collect("b2b_1", 32'hB000_0001, 8, 8'hFF, 1'b0, 1'b0, 0, 0, 0, fc1, lc1);
      check_done("b2b_1", 32'h0000_0040);
      collect("b2b_2", 32'hB000_0002, 200, 8'hFF, 1'b0, 1'b1, 0, 0, 0, fc2, lc2);
      compared++;
      if (fc2 - lc1 - 1 < 4) begin
         mismatched++;
         $display("FAIL b2b_gap: got %0d idle cycles required >= 4", fc2 - lc1 - 1);
      end
      check_done("b2b_2", 32'h0000_0640);
   endtask

   task automatic test_reset_mid_frame();
      int pops = 0;
      int fc, lc;
      @(negedge rx_mac_aclk);
      rx_axis_mac_tready = 1'b1;
      push_words(32'hC000_0001, 0, 8);
      push_bcnt(32'd64);
      for (int t = 0; t < 40 && pops < 3; t++) begin
         @(negedge rx_mac_aclk);
         if (rx_axis_mac_tvalid && rx_axis_mac_tready) pops++;
      end
      compared++;
      if ({pops, axis_rd_state} !== {32'd3, 4'h4}) begin
         mismatched++;
         $display("FAIL mid_frame_reach: got pops=%0d state=%h required 3 4", pops, axis_rd_state);
      end
      reset_ = 1'b0;
      @(negedge rx_mac_aclk);
      check_all_zero("reset_mid_frame");
      reset_ = 1'b1;
      bq.delete();
      dq.delete();
      rxbcnt_rdempty = 1'b1;
      rxdata_rdempty = 1'b1;
      @(negedge rx_mac_aclk);
      check_all_zero("idle_after_mid_reset");
      push_words(32'hD000_0001, 0, 1);
      push_bcnt(32'd1);
      collect("one_byte", 32'hD000_0001, 1, 8'h01, 1'b0, 1'b0, 0, 0, 0, fc, lc);
      check_done("one_byte", 32'h0000_0001);
   endtask

   initial begin
      reset_             = 1'b0;
      rx_axis_mac_tready = 1'b0;
      rd_rxbcnt_fifo     = '0;
      rd_rxdata_fifo     = '0;
      rxbcnt_rdempty     = 1'b1;
      rxdata_rdempty     = 1'b1;
      rxbcnt_rdusedw     = '0;
      rxdata_rdusedw     = '0;
      test_reset();
      test_basic64();
      test_rem61();
      test_err_backpressure();
      test_stall();
      test_zero();
      test_back_to_back();
      test_reset_mid_frame();
      repeat (2) @(negedge rx_mac_aclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
